// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register. Optional two-entry skid
//               buffer for a registered in_ready, synchronous flush with a
//               bubble value, and a saturating back-pressure stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = '0,
    parameter bit                SKID   = 1'b1,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_stall;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign w_stall    = out_valid & ~out_ready;

    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;

    generate
        if (SKID) begin : g_skid
            // State encoding doubles as the occupancy count.
            localparam logic [1:0] c_EMPTY = 2'd0;
            localparam logic [1:0] c_ONE   = 2'd1;
            localparam logic [1:0] c_TWO   = 2'd2;

            logic [1:0]       r_state;
            logic             r_main_valid;
            logic             r_in_ready;
            logic [WIDTH-1:0] r_main_data;
            logic [WIDTH-1:0] r_skid_data;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_state      <= c_EMPTY;
                    r_main_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                    r_main_data  <= BUBBLE;
                    r_skid_data  <= BUBBLE;
                end else if (flush) begin
                    r_state      <= c_EMPTY;
                    r_main_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                    r_main_data  <= BUBBLE;
                    r_skid_data  <= BUBBLE;
                end else begin
                    case (r_state)
                        c_EMPTY: begin
                            if (w_in_xfer) begin
                                r_state      <= c_ONE;
                                r_main_valid <= 1'b1;
                                r_main_data  <= in_data;
                            end
                        end
                        c_ONE: begin
                            if (w_in_xfer && !w_out_xfer) begin
                                r_state     <= c_TWO;
                                r_skid_data <= in_data;
                                r_in_ready  <= 1'b0;
                            end else if (!w_in_xfer && w_out_xfer) begin
                                r_state      <= c_EMPTY;
                                r_main_valid <= 1'b0;
                                r_main_data  <= BUBBLE;
                            end else if (w_in_xfer && w_out_xfer) begin
                                r_main_data <= in_data;
                            end
                        end
                        c_TWO: begin
                            if (w_out_xfer) begin
                                r_state     <= c_ONE;
                                r_main_data <= r_skid_data;
                                r_skid_data <= BUBBLE;
                                r_in_ready  <= 1'b1;
                            end
                        end
                        default: begin
                            r_state      <= c_EMPTY;
                            r_main_valid <= 1'b0;
                            r_in_ready   <= 1'b1;
                            r_main_data  <= BUBBLE;
                            r_skid_data  <= BUBBLE;
                        end
                    endcase
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = r_main_valid;
            assign out_data  = r_main_data;
            assign occupancy = r_state;
        end else begin : g_no_skid
            logic             r_valid;
            logic [WIDTH-1:0] r_data;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_valid <= 1'b0;
                    r_data  <= BUBBLE;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    r_data  <= BUBBLE;
                end else if (w_in_xfer) begin
                    r_valid <= 1'b1;
                    r_data  <= in_data;
                end else if (w_out_xfer) begin
                    r_valid <= 1'b0;
                    r_data  <= BUBBLE;
                end
            end

            assign in_ready  = ~r_valid | out_ready;
            assign out_valid = r_valid;
            assign out_data  = r_data;
            assign occupancy = {1'b0, r_valid};
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic parametrised pipeline stage register replacing the per-stage fixed registers between fetch/decode/execute/writeback. It carries a WIDTH-bit payload under a valid/ready handshake, with an optional two-entry skid buffer so that `in_ready` is fully registered. It supports a synchronous flush that inserts a programmable bubble value, and a saturating back-pressure counter for performance monitoring.

## Interface
- `WIDTH`, 32, payload width in bits (≥1)
- `BUBBLE`, all zeros, payload value presented when the stage is empty, flushed or in reset
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry, combinational `in_ready`
- `CNT_W`, 16, stall counter width (≥2)

- `clk` in 1 — single clock, rising edge
- `rstn` in 1 — reset, asynchronous assert, active-low
- `in_valid` in 1 — upstream payload valid
- `in_ready` out 1 — stage can accept the upstream payload
- `in_data` in WIDTH — upstream payload
- `out_valid` out 1 — stage holds a valid payload
- `out_ready` in 1 — downstream accepts the payload
- `out_data` out WIDTH — payload to downstream
- `flush` in 1 — synchronous squash of all stored entries
- `cnt_clr` in 1 — synchronous clear of `stall_cnt`
- `occupancy` out 2 — number of valid entries (0..2; max 1 when SKID=0)
- `stall_cnt` out CNT_W — cycles with `out_valid & ~out_ready`, saturating

## Operation
- Input transfer: `in_valid & in_ready` at a rising edge. Output transfer: `out_valid & out_ready` at a rising edge.
- Storage: main entry (drives `out_data`/`out_valid`); skid entry exists only when SKID=1.
- State machine for SKID=1:
  - EMPTY (occ 0)
  - ONE (main valid)
  - TWO (main and skid valid)
- Transitions:
  - EMPTY + input transfer → ONE; main ← `in_data`.
  - ONE + input only → TWO; skid ← `in_data`.
  - ONE + output only → EMPTY.
  - ONE + both → ONE; main ← `in_data`.
  - TWO + output → ONE; main ← skid. No input transfer is possible in TWO.
  - Otherwise hold.
- SKID=1: `in_ready` = registered `~skid_valid`, so it is 0 only in TWO.
- SKID=0: states EMPTY/ONE only. `in_ready = ~out_valid | out_ready` (combinational). ONE with both transfers → ONE with new data.
- Ordering is strictly FIFO. No payload is duplicated or dropped except by `flush`.
- Bubble: any entry that becomes invalid is loaded with BUBBLE. `out_data` equals BUBBLE whenever `out_valid`=0.
- Flush has the highest priority. Next state is EMPTY, all entries become BUBBLE, and any coincident input transfer is discarded. A coincident output transfer still counts as completed for downstream.
- Stall counter:
  - Increments by 1 each cycle `out_valid & ~out_ready`, saturating at 2^CNT_W−1.
  - `cnt_clr` forces it to 0 and takes priority over increment.
  - `flush` does not clear it.

## Timing
- Reset (`rstn`=0, asynchronous, immediate):
  - `out_valid`=0, `out_data`=BUBBLE, `occupancy`=0, `stall_cnt`=0.
  - `in_ready`=1 for SKID=1; `in_ready` follows its equation for SKID=0, which gives 1.
- Reset mid-operation discards all entries. The first transfer is possible on the first rising edge after `rstn` deasserts.
- Latency: a payload accepted at edge N is visible on `out_*` after edge N with no added bubble. Throughput is 1 per cycle while `out_ready`=1.
- SKID=1: `in_ready` falls in the cycle after the edge that enters TWO, and rises in the cycle after the edge that leaves TWO. No combinational path from `out_ready` to `in_ready`.
- Flush: `out_valid`=0 in the cycle after the flush edge. `in_ready`=1 in that cycle.
- `occupancy` and `stall_cnt` are registered and update on the same edge as the state.

## Test plan
- Reset/bubble, BUBBLE=32'hDEAD_BEEF:
  - Stimulus: assert `rstn`=0 mid-stream.
  - Required: `out_valid`=0, `out_data`=32'hDEADBEEF, `occupancy`=0 immediately, without waiting for a clock edge.
- Streaming:
  - Stimulus: `out_ready`=1; drive 1,2,3,4 on consecutive cycles.
  - Required: `out_data` shows 1,2,3,4 one cycle later, back-to-back; `stall_cnt`=0.
- Skid fill, SKID=1:
  - Stimulus: `out_ready`=0; offer 10,11,12.
  - Required: 10 and 11 accepted, `occupancy`=2, `in_ready`=0, 12 held upstream.
  - Then raise `out_ready`: outputs 10,11,12 in order, with nothing lost or duplicated.
- Flush collision:
  - Stimulus: in TWO, assert `flush` together with `in_valid`.
  - Required: next cycle `out_valid`=0, `occupancy`=0, `out_data`=BUBBLE; the input payload never appears.
- Stall counter, CNT_W=2:
  - Stimulus: hold `out_valid`=1, `out_ready`=0 for 5 cycles.
  - Required: `stall_cnt` goes 1,2,3,3,3. `cnt_clr` with a stall in the same cycle → 0.
- SKID=0:
  - Stimulus: `out_valid`=1, toggle `out_ready` with `in_valid`=1.
  - Required: `in_ready` tracks `out_ready` in the same cycle; `occupancy` never exceeds 1.
